// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_seq_pkg                                                |
// | Description : State codes, counter width and output decode for rst_seq.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package rst_seq_pkg;

    localparam int CNT_W   = 16;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_MEM_REL   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_HOLD   = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic mem_rst_n;
        logic cpu_rst_n;
        logic cpu_clk_en;
    } rst_out_t;

    localparam rst_out_t c_out_hold = 3'b000;
    localparam rst_out_t c_out_mem  = 3'b100;
    localparam rst_out_t c_out_run  = 3'b111;

    function automatic rst_out_t decode_outputs(input seq_state_e state);
        rst_out_t out;
        case (state)
            ST_MEM_REL, ST_SW_HOLD: out = c_out_mem;
            ST_RUN:                 out = c_out_run;
            default:                out = c_out_hold;
        endcase
        return out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_seq_if                                                 |
// | Description : Lock/request inputs and reset outputs of the sequencer.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface rst_seq_if;
    import rst_seq_pkg::*;

    logic               pll_locked;
    logic               sw_rst_req;
    logic               mem_rst_n;
    logic               cpu_rst_n;
    logic               cpu_clk_en;
    logic [STATE_W-1:0] seq_state;

    modport master (
        input  pll_locked, sw_rst_req,
        output mem_rst_n, cpu_rst_n, cpu_clk_en, seq_state
    );

    modport slave (
        output pll_locked, sw_rst_req,
        input  mem_rst_n, cpu_rst_n, cpu_clk_en, seq_state
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_2ff                                                   |
// | Description : 1-bit two-flop synchronizer, async active-low reset to 0.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_seq                                                    |
// | Description : PLL-lock driven memory/CPU reset release sequencer.        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int LOCK_CYCLES   = 1024,
    parameter int MEM_CYCLES    = 16,
    parameter int SW_RST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    rst_seq_if.master  bus
);

    localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_mem_last  = CNT_W'(MEM_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_sw_last   = CNT_W'(SW_RST_CYCLES - 1);

    logic             w_lock_s;
    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    rst_out_t         r_out;
    rst_out_t         w_out_nxt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (w_lock_s)
    );

    // Counter defaults to zero so every state change clears it on entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if ((r_state != ST_WAIT_LOCK) && !w_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_lock_s) w_state_nxt = ST_STABLE;
                end
                ST_STABLE: begin
                    if (r_cnt == c_lock_last) w_state_nxt = ST_MEM_REL;
                    else                      w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
                ST_MEM_REL: begin
                    if (r_cnt == c_mem_last) w_state_nxt = ST_RUN;
                    else                     w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
                ST_RUN: begin
                    if (bus.sw_rst_req) w_state_nxt = ST_SW_HOLD;
                end
                ST_SW_HOLD: begin
                    if (r_cnt == c_sw_last) w_state_nxt = ST_RUN;
                    else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
                default: w_state_nxt = ST_WAIT_LOCK;
            endcase
        end
        w_out_nxt = decode_outputs(w_state_nxt);
    end

    // Outputs are decoded from the next state so they flip on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
            r_out   <= c_out_hold;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign bus.mem_rst_n  = r_out.mem_rst_n;
    assign bus.cpu_rst_n  = r_out.cpu_rst_n;
    assign bus.cpu_clk_en = r_out.cpu_clk_en;
    assign bus.seq_state  = r_state;

endmodule
`default_nettype wire

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024, meaning clk cycles of continuous synchronized lock required before the memory reset is released (range 1..65535).
REQ-002 SHALL have parameter MEM_CYCLES, default 16, meaning clk cycles between the memory reset release and the CPU reset release (range 1..65535).
REQ-003 SHALL have parameter SW_RST_CYCLES, default 8, meaning clk cycles the CPU is held in reset after a software reset request (range 1..65535).
REQ-004 SHALL have port clk, input, 1, the single clock, the free-running clock-wizard output; all flops use its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port pll_locked, input, 1, the clock-wizard lock indicator, asynchronous to clk.
REQ-007 SHALL have port sw_rst_req, input, 1, a software/debug CPU reset request, synchronous to clk, sampled every cycle.
REQ-008 SHALL have port mem_rst_n, output, 1, the active-low reset for instruction/data memories.
REQ-009 SHALL have port cpu_rst_n, output, 1, the active-low reset for the RISCV core.
REQ-010 SHALL have port cpu_clk_en, output, 1, the clock enable for the core, replacing AND-gating of the clock with lock.
REQ-011 SHALL have port seq_state, output, 3, the current state encoding, for debug.

Function
REQ-012 SHALL pass pll_locked through a 2-flop synchronizer, giving lock_s; lock_s is the only form of lock used internally.
REQ-013 SHALL implement the states WAIT_LOCK=0, STABLE=1, MEM_REL=2, RUN=3 and SW_HOLD=4, with the cycle counter cleared on every state entry.
REQ-014 In WAIT_LOCK, lock_s=1 SHALL cause a move to STABLE on the next edge.
REQ-015 STABLE SHALL last exactly LOCK_CYCLES cycles (the counter reaches LOCK_CYCLES-1) and then move to MEM_REL.
REQ-016 MEM_REL SHALL last exactly MEM_CYCLES cycles and then move to RUN.
REQ-017 In RUN, sw_rst_req=1 SHALL cause a move to SW_HOLD, which lasts exactly SW_RST_CYCLES cycles and then returns to RUN.
REQ-018 sw_rst_req SHALL be ignored in every state except RUN, including during SW_HOLD, with no queuing.
REQ-019 lock_s=0 in any state except WAIT_LOCK SHALL move the FSM to WAIT_LOCK on the next edge.
  - This has priority over the counter expiry and over sw_rst_req.
REQ-020 The outputs SHALL be registered, updating on the same edge as the state register, and SHALL be decoded as follows.
  - mem_rst_n=1 only in MEM_REL, RUN and SW_HOLD.
  - cpu_rst_n=1 and cpu_clk_en=1 only in RUN.
  - seq_state equals the state code.
REQ-021 Outputs SHALL be glitch-free: each changes at most once per edge, and there is no combinational path from any input to any output.
REQ-022 The counter SHALL be 16 bits, compare by equality and never wrap; it is unused (held at 0) in WAIT_LOCK and RUN.
REQ-023 Loss of lock SHALL reach outputs low within 3 clk edges of pll_locked falling (2 synchronizer edges plus 1 FSM edge).

Reset
REQ-024 rst_n=0 SHALL asynchronously force the following, regardless of clk:
  - state to WAIT_LOCK;
  - counter and both synchronizer flops to 0;
  - mem_rst_n, cpu_rst_n and cpu_clk_en to 0;
  - seq_state to 0.
REQ-025 Deassertion of rst_n SHALL take effect only at a rising clk edge, and the sequence SHALL always restart from WAIT_LOCK, including when rst_n is asserted mid-operation.

Structure
REQ-026 The state codes, the counter width constant (CNT_W=16) and the output-decode constants SHALL live in the shared package rst_seq_pkg.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, async active-low reset to 0), reusable elsewhere in the codebase.
REQ-028 rst_seq SHALL sit between the clock wizard and RISCV; the core consumes cpu_rst_n and cpu_clk_en.

Verification (LOCK_CYCLES=8, MEM_CYCLES=4, SW_RST_CYCLES=3)
REQ-029 Power-up: pll_locked rises before edge 1.
  - Required: mem_rst_n high after edge 11.
  - Required: cpu_rst_n and cpu_clk_en high after edge 15.
  - Required: seq_state sequence 0,1,2,3.
REQ-030 Lock glitch: pll_locked low for 1 cycle while STABLE has counter=5.
  - Required: return to WAIT_LOCK, full 8-cycle STABLE restart.
  - Required: mem_rst_n never rises early.
REQ-031 Lock loss in RUN.
  - Required: mem_rst_n, cpu_rst_n and cpu_clk_en all 0 by the 3rd edge after the fall.
  - Required: the sequence re-runs once lock returns.
REQ-032 sw_rst_req 1-cycle pulse in RUN.
  - Required: cpu_rst_n and cpu_clk_en low for exactly 3 cycles, mem_rst_n stays 1.
  - Required: a second pulse during SW_HOLD has no effect.
REQ-033 sw_rst_req and lock_s falling on the same edge in RUN.
  - Required: next state is WAIT_LOCK and all outputs go to 0.
REQ-034 rst_n pulsed low between edges during MEM_REL.
  - Required: outputs drop to 0 immediately, without waiting for a clk edge.
  - Required: after release, the sequence restarts from WAIT_LOCK.
